// File: rtl/mips_lsu_pkg.sv
// Shared encodings, request payload and alignment check for the MIPS load/store unit.
package mips_lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic            we;
    logic [1:0]      size;
    logic            is_unsigned;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Reserved size or an address not aligned to the access size.
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mips_load_store_unit_lane_mux.sv
// Byte/half lane extraction for loads and lane merge for read-modify-write stores.
module lsu_lane_mux
  import mips_lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] store_word_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = word[{addr_lo, 3'b000} +: 8];
    half_sel     = addr_lo[1] ? word[31:16] : word[15:0];
    load_data_c  = word;
    store_word_c = wdata;
    case (size)
      SZ_BYTE: begin
        load_data_c  = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
        store_word_c = word;
        store_word_c[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data_c  = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
        store_word_c = word;
        if (addr_lo[1]) store_word_c[31:16] = wdata[15:0];
        else            store_word_c[15:0]  = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// Data-memory initiator for MIPS lb/lbu/lh/lhu/lw/sb/sh/sw with RMW sub-word stores.
// Optional MIPS_LSU_BOUND_CHECK_EN flags word indices >= DEPTH as errors.
module mips_load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [WIDTH-1:0] mem_A,
  output logic [WIDTH-1:0] mem_WD,
  output logic             mem_WE,
  input  logic [WIDTH-1:0] mem_RD
);

`ifdef MIPS_LSU_BOUND_CHECK_EN
  localparam bit BOUND_CHECK = 1'b1;
`else
  localparam bit BOUND_CHECK = 1'b0;
`endif

  lsu_state_t      state;
  lsu_req_t        req_q;
  logic            access_err;
  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] store_word_c;

  assign access_err = access_fault(req_size, req_addr[1:0])
                    | (BOUND_CHECK & (WIDTH'(req_addr[WIDTH-1:2]) >= WIDTH'(DEPTH)));

  // Lane logic works on the live read data so results land in registers at the READ edge.
  lsu_lane_mux u_lane_mux (
    .word         (mem_RD),
    .addr_lo      (req_q.addr_lo),
    .size         (req_q.size),
    .is_unsigned  (req_q.is_unsigned),
    .wdata        (req_q.wdata),
    .load_data_c  (load_data_c),
    .store_word_c (store_word_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_A      <= '0;
      mem_WD     <= '0;
      mem_WE     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q     <= '{we: req_we, size: req_size, is_unsigned: req_unsigned,
                           addr_lo: req_addr[1:0], wdata: req_wdata};
            req_ready <= 1'b0;
            if (access_err) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              mem_A <= WIDTH'(req_addr[WIDTH-1:2]);
              if (req_we && (req_size == SZ_WORD)) begin
                state  <= ST_WRITE;
                mem_WE <= 1'b1;
                mem_WD <= req_wdata;
              end else begin
                state <= ST_READ;
              end
            end
          end
        end
        ST_READ: begin
          if (req_q.we) begin
            state  <= ST_WRITE;
            mem_WE <= 1'b1;
            mem_WD <= store_word_c;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data_c;
          end
        end
        ST_WRITE: begin
          state      <= ST_RESP;
          mem_WE     <= 1'b0;
          resp_valid <= 1'b1;
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Bench for mips_load_store_unit: memory model, reference model and per-cycle checker.
module tb_mips_load_store_unit;

`ifdef MIPS_LSU_BOUND_CHECK_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif
  localparam int unsigned DEPTH = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  mips_load_store_unit #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
    .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  // Environment memory (what the DUT talks to) and the model's own copy.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  assign mem_RD = mem[mem_A[7:0]];
  always @(posedge clk) if (mem_WE) mem[mem_A[7:0]] <= mem_WD;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int unsigned cyc; logic err; logic [31:0] rdata; } resp_exp_t;
  typedef struct { int unsigned cyc; logic [31:0] a; logic [31:0] wd; } wr_exp_t;
  resp_exp_t rq[$];
  wr_exp_t   wq[$];
  logic [31:0] last_rdata;
  logic        last_err;

  // Every cycle: resp_valid and mem_WE must occur exactly where the model scheduled them.
  always @(negedge clk) begin
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      chk("resp_valid", 32'(resp_valid), 32'd1);
      if (resp_valid) begin
        chk("resp_err", 32'(resp_err), 32'(rq[0].err));
        chk("resp_rdata", resp_rdata, rq[0].rdata);
        last_rdata = resp_rdata;
        last_err   = resp_err;
      end
      void'(rq.pop_front());
    end else begin
      chk("resp_valid_idle", 32'(resp_valid), 32'd0);
    end
    if (wq.size() > 0 && wq[0].cyc == cyc) begin
      chk("mem_WE", 32'(mem_WE), 32'd1);
      if (mem_WE) begin
        chk("mem_A", mem_A, wq[0].a);
        chk("mem_WD", mem_WD, wq[0].wd);
      end
      void'(wq.pop_front());
    end else begin
      chk("mem_WE_idle", 32'(mem_WE), 32'd0);
    end
  end

  // Drive one request, derive the architectural outcome and schedule the expected events.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] idx, off, word, v, mask, nw, sh;
    logic        err;
    int unsigned lat, n;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    idx  = addr / 4;
    off  = addr % 4;
    err  = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) ||
           (size == 2'd2 && off != 0) || (BOUND && idx >= DEPTH);
    lat  = err ? 1 : (!we ? 2 : (size == 2'd2 ? 2 : 3));
    word = ref_mem[idx[7:0]];
    v = 32'd0;
    nw = word;
    if (!err) begin
      if (size == 2'd0) begin
        sh = 8 * off;
        v = (word >> sh) & 32'hFF;
        if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        mask = 32'hFF << sh;
        nw = (word & ~mask) | ((wdata & 32'hFF) << sh);
      end else if (size == 2'd1) begin
        sh = 16 * (off / 2);
        v = (word >> sh) & 32'hFFFF;
        if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        mask = 32'hFFFF << sh;
        nw = (word & ~mask) | ((wdata & 32'hFFFF) << sh);
      end else begin
        v = word;
        nw = wdata;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = cyc;
    rq.push_back('{cyc: n + lat - 1, err: err, rdata: (we || err) ? 32'd0 : v});
    if (we && !err) begin
      wq.push_back('{cyc: n + lat - 2, a: idx, wd: nw});
      ref_mem[idx[7:0]] = nw;
    end
    repeat (lat) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem[3] = 32'h11223344;  ref_mem[3] = 32'h11223344;
    mem[99] = 32'h5A5A0099; ref_mem[99] = 32'h5A5A0099;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    last_rdata = 32'd0; last_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_A", mem_A, 32'd0);
    chk("rst_mem_WD", mem_WD, 32'd0);
    rst = 1'b1;

    do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF);
    chk("sw_mem2", mem[2], 32'hDEADBEEF);
    do_req(1'b0, 2'd0, 1'b0, 32'h0B, 32'd0); chk("lb_0B", last_rdata, 32'hFFFFFFDE);
    do_req(1'b0, 2'd0, 1'b1, 32'h0B, 32'd0); chk("lbu_0B", last_rdata, 32'h000000DE);
    do_req(1'b0, 2'd1, 1'b0, 32'h08, 32'd0); chk("lh_08", last_rdata, 32'hFFFFBEEF);
    do_req(1'b0, 2'd1, 1'b1, 32'h08, 32'd0); chk("lhu_08", last_rdata, 32'h0000BEEF);
    do_req(1'b0, 2'd1, 1'b0, 32'h0A, 32'd0); chk("lh_0A", last_rdata, 32'hFFFFDEAD);
    do_req(1'b1, 2'd0, 1'b0, 32'h09, 32'h12);
    chk("sb_mem2", mem[2], 32'hDEAD12EF);
    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'd0); chk("lw_after_sb", last_rdata, 32'hDEAD12EF);
    do_req(1'b0, 2'd0, 1'b0, 32'h08, 32'd0); chk("lb_08", last_rdata, 32'hFFFFFFEF);

    // Errors: one-cycle latency, zero data, no memory write.
    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'd0);
    chk("lw_06_err", 32'(last_err), 32'd1); chk("lw_06_rdata", last_rdata, 32'd0);
    do_req(1'b1, 2'd1, 1'b0, 32'h03, 32'hFFFF);
    chk("sh_03_err", 32'(last_err), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h04, 32'd0);
    chk("size11_err", 32'(last_err), 32'd1);

    // Reset during the WRITE cycle of a sub-word store aborts it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h0C; req_wdata = 32'h0000CAFE;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_we_high", 32'(mem_WE), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_we_drop", 32'(mem_WE), 32'd0);
    chk("abort_resp", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_mem3", mem[3], 32'h11223344);

    do_req(1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000ABCD);
    do_req(1'b0, 2'd2, 1'b0, 32'h0C, 32'd0); chk("lw_after_sh", last_rdata, 32'hABCD3344);
    do_req(1'b1, 2'd0, 1'b0, 32'h0B, 32'h80);
    do_req(1'b0, 2'd0, 1'b0, 32'h0B, 32'd0); chk("lb_0B_80", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'd0); chk("lw_08_final", last_rdata, 32'h80AD12EF);

    do_req(1'b0, 2'd2, 1'b0, 32'h18C, 32'd0);
    chk("lw_18C", last_rdata, 32'h5A5A0099);
    do_req(1'b0, 2'd2, 1'b0, 32'h190, 32'd0);
    chk("lw_190_err", 32'(last_err), 32'(BOUND));

    repeat (5) @(negedge clk);
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mips_load_store_unit.md
Name: mips_load_store_unit

Overview:
- Initiator side of the data-memory interface.
- Accepts load/store requests from the MIPS datapath (lb/lbu/lh/lhu/lw/sb/sh/sw) and drives the word-addressed data memory's A/WD/WE ports, consuming its combinational RD.
- Sub-word stores are performed as read-modify-write.
- Results return on a one-cycle response pulse; misaligned or illegal accesses are flagged without touching memory.

Parameters:
- WIDTH, 32, data/address width; only 32 supported.
- DEPTH, 100, memory depth in words; used by the optional bound check.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  loads: zero-extend if 1, sign-extend if 0.
- req_addr  input  WIDTH  byte address.
- req_wdata  input  WIDTH  store data; the low bytes are used for sub-word stores.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  WIDTH  load result; 0 for stores and errors.
- resp_err  output  1  misaligned, reserved size or (optional) out-of-bounds access.
- mem_A  output  WIDTH  word index, equal to byte address >> 2.
- mem_WD  output  WIDTH  write data to memory.
- mem_WE  output  1  memory write enable.
- mem_RD  input  WIDTH  combinational read data for mem_A.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. State, request registers and the captured word are cleared asynchronously when rst=0.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_WE=0, mem_A=0, mem_WD=0.
- Memory-side outputs are decoded from registered state only; no combinational path runs from req_* to mem_*.
- IDLE: on req_valid=1, latch addr, size, we, unsigned and wdata, then:
  - Error (size=11; half with addr[0]=1; word with addr[1:0]!=0) -> RESP with err=1. No memory cycle.
  - Load, or byte/half store -> READ.
  - Word store -> WRITE.
- READ (1 cycle): mem_A=addr>>2. Capture mem_RD at the clock edge. Load -> RESP; sub-word store -> WRITE.
- WRITE (1 cycle): mem_WE=1, mem_A=addr>>2.
  - Word store: mem_WD = wdata.
  - Sub-word store: mem_WD = captured word with the selected lane replaced.
  - Byte lane = addr[1:0], little-endian (byte 0 = bits 7:0). Half lane = addr[1] (0 -> bits 15:0).
  - Next state -> RESP.
- RESP (1 cycle): resp_valid=1 and resp_err as determined. resp_rdata is the extracted lane, sign- or zero-extended, for a successful load; otherwise 0. Next state -> IDLE.
- Latency from accept edge to resp_valid high:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Throughput: the next request can be accepted on the cycle after RESP. There is no response backpressure; the datapath stalls on req_ready=0.
- req_valid outside IDLE is ignored. A request is not held pending.
- mem_WE is high for exactly one cycle per store, never for loads or errors.
- Reset mid-operation aborts the access: an in-progress WRITE is dropped, nothing partial is written after reset, and no resp_valid is produced.

Optional Feature:
- MIPS_LSU_BOUND_CHECK_EN defined: word index (addr>>2) >= DEPTH is treated as an error, with the same path as misalignment (no memory access, err=1, 1-cycle latency).
- Not defined: the index is passed through unchecked, and the memory's behaviour for out-of-range indices applies.

Decomposition:
- Package mips_lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state encoding;
  - an alignment-check function.
- One sub-module, lsu_lane_mux (combinational): given word, addr[1:0], size and unsigned, produces extracted load data and the merged store word. The FSM is in the top.

Test Plan:
- Reset, then sw addr=0x08 data=0xDEADBEEF -> mem_WE pulse with mem_A=2 and mem_WD=0xDEADBEEF; resp_valid 2 cycles after accept; err=0.
- Word 2=0xDEADBEEF; lb addr=0x0B -> rdata=0xFFFFFFDE; lbu addr=0x0B -> 0x000000DE; lh addr=0x08 -> 0xFFFFBEEF; lhu -> 0x0000BEEF.
- Word 2=0xDEADBEEF; sb addr=0x09 data=0x12 -> one WE cycle, WD=0xDEAD12EF, resp 3 cycles after accept; a following lw 0x08 returns 0xDEAD12EF.
- lw addr=0x06, sh addr=0x03, size=11 -> each: resp_valid 1 cycle after accept, err=1, rdata=0, mem_WE never asserted.
- Assert rst=0 during WRITE of sh addr=0x0C -> mem_WE drops immediately, word 3 unchanged, no resp_valid, req_ready=1 after release.
- With MIPS_LSU_BOUND_CHECK_EN and DEPTH=100: lw addr=0x190 (index 100) -> err=1, no memory access; lw addr=0x18C -> normal access, err=0.
